seq_restoring_divider: RTL
==========================

// Module: seq_restoring_divider
// PURPOSE
//  Iterative unsigned restoring divider: quotient = dividend / divisor, remainder = dividend % divisor.
//  Inverse arithmetic companion to the team's 8x8 array/tree multipliers.
//  Resolves one quotient bit per clock behind a start/busy/done handshake.
//  Sits in datapath blocks that need division but cannot afford a combinational array.
// PARAMETERS
//  WIDTH  8  operand width; dividend, divisor, quotient and remainder are all WIDTH bits
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      synchronous, active-high reset
//  start      in   1      request; sampled only in IDLE
//  dividend   in   WIDTH  unsigned numerator; captured on the accepted start edge
//  divisor    in   WIDTH  unsigned denominator; captured on the accepted start edge
//  busy       out  1      high whenever state != IDLE
//  done       out  1      one-cycle pulse; quotient, remainder and div_by_zero valid in that cycle
//  quotient   out  WIDTH  result; held until the next completion
//  remainder  out  WIDTH  result; held until the next completion
//  div_by_zero out 1      set with done when the captured divisor was 0; held with the results
// BEHAVIOUR
//  Reset: state=IDLE. busy, done, quotient, remainder, div_by_zero and all internal registers = 0.
//   rst overrides every other input, including mid-division. The operation in flight is discarded
//   with no done pulse.
//  FSM: IDLE -> DIV -> DONE -> IDLE. A division by zero takes IDLE -> DONE directly.
//  IDLE: on an edge with start=1:
//   - divisor != 0: capture operands, clear the partial remainder (WIDTH+1 bits), set count=0, go to DIV.
//   - divisor == 0: quotient={WIDTH{1'b1}}, remainder=dividend, div_by_zero=1, go to DONE.
//  DIV: one restoring step per edge:
//   - P = {P[WIDTH-1:0], Q[WIDTH-1]}; Q <<= 1
//   - if P >= {1'b0,D}: P -= D and Q[0]=1
//   - count increments; the step with count==WIDTH-1 is the last one.
//  End of the last step: results are loaded into quotient/remainder, div_by_zero=0, next state DONE.
//  DONE: done=1 and busy=1 for exactly one cycle, then IDLE unconditionally.
//  Latency: accepted start edge at cycle T -> done high in cycle T+WIDTH+1.
//   The divide-by-zero path: done high in cycle T+1.
//  Throughput: a new start is accepted in the first IDLE cycle after DONE. Back-to-back period = WIDTH+2 cycles.
//  start in DIV or DONE is ignored, not queued. Operand changes after capture have no effect.
//  Edge cases:
//   - dividend < divisor: quotient=0, remainder=dividend.
//   - divisor=1: quotient=dividend, remainder=0.
//   - dividend=0: quotient=0, remainder=0.
//  Invariant: whenever done=1 and div_by_zero=0, quotient*divisor + remainder == dividend and remainder < divisor.
//  Outputs are registered; no combinational path from any input to any output.
// TESTING
//  1. Reset: rst=1 for 2 cycles -> busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
//  2. Basic divide: start with 100/7 -> done in cycle T+9, quotient=14, remainder=2, div_by_zero=0.
//     busy high in cycles T+1..T+9.
//  3. Boundaries: 255/1 -> 255,0. 5/9 -> 0,5. 0/3 -> 0,0. 255/255 -> 1,0. Each completes in 9 cycles.
//  4. Divide by zero: 200/0 -> done in cycle T+1, quotient=255, remainder=200, div_by_zero=1.
//     The next 10/3 then gives 3,1 with div_by_zero=0.
//  5. Protocol:
//     - Pulse start again with 50/5 during DIV -> ignored; the first result 100/7 is still 14,2.
//     - start held high continuously -> a new division begins 1 cycle after each done.
//  6. Reset mid-op: assert rst 4 cycles into 100/7 -> no done pulse, all outputs 0.
//     Then run a random-sweep check of the invariant over all 65536 operand pairs for WIDTH=8.

Source files
------------

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock behind a
// start/busy/done handshake, with a one-cycle shortcut for a zero divisor.
module seq_restoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    // Partial remainder is one bit wider than the divisor so the trial
    // subtraction can never overflow.
    logic [WIDTH:0]   p_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   p_shift;
    logic [WIDTH:0]   p_next;
    logic [WIDTH-1:0] q_next;
    logic             last_step;

    always_comb begin
        p_shift   = {p_reg[WIDTH-1:0], q_reg[WIDTH-1]};
        p_next    = p_shift;
        q_next    = {q_reg[WIDTH-2:0], 1'b0};
        last_step = (count == CW'(WIDTH - 1));
        if (p_shift >= {1'b0, d_reg}) begin
            p_next    = p_shift - {1'b0, d_reg};
            q_next[0] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (divisor == '0) ? DONE : DIV;
                end
            end
            DIV: begin
                busy = 1'b1;
                if (last_step) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Results stay registered and untouched until the next completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_reg       <= '0;
            q_reg       <= '0;
            d_reg       <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            p_reg <= '0;
                            q_reg <= dividend;
                            d_reg <= divisor;
                            count <= '0;
                        end
                    end
                end
                DIV: begin
                    p_reg <= p_next;
                    q_reg <= q_next;
                    count <= count + CW'(1);
                    if (last_step) begin
                        quotient    <= q_next;
                        remainder   <= p_next[WIDTH-1:0];
                        div_by_zero <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
